// File: rtl/placar_pkg.sv
// Shared types, segment patterns and BCD step helpers for the score counter.
// Segment vectors are ordered {a,b,c,d,e,f,g}, active-high.
package placar_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;

    typedef struct packed {
        bcd_t dez;
        bcd_t uni;
    } placar_t;

    localparam int NBTN    = 2;
    localparam int BTN_INC = 0;
    localparam int BTN_DEC = 1;

    localparam seg_t SEG_0     = 7'b1111110;
    localparam seg_t SEG_1     = 7'b0110000;
    localparam seg_t SEG_2     = 7'b1101101;
    localparam seg_t SEG_3     = 7'b1111001;
    localparam seg_t SEG_4     = 7'b0110011;
    localparam seg_t SEG_5     = 7'b1011011;
    localparam seg_t SEG_6     = 7'b1011111;
    localparam seg_t SEG_7     = 7'b1110000;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1111011;
    localparam seg_t SEG_BLANK = 7'b0000000;

    localparam placar_t PLACAR_ZERO = '{dez: 4'd0, uni: 4'd0};

    function automatic placar_t placar_inc(input placar_t c);
        placar_t n;
        n = c;
        if (c.uni == 4'd9) begin
            n.uni = 4'd0;
            n.dez = (c.dez == 4'd9) ? 4'd0 : c.dez + 4'd1;
        end else begin
            n.uni = c.uni + 4'd1;
        end
        return n;
    endfunction

    function automatic placar_t placar_dec(input placar_t c);
        placar_t n;
        n = c;
        if (c.uni == 4'd0) begin
            n.uni = 4'd9;
            n.dez = (c.dez == 4'd0) ? 4'd9 : c.dez - 4'd1;
        end else begin
            n.uni = c.uni - 4'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/decod_bcd_7seg.sv
// BCD digit to 7-segment pattern, purely combinational.
// Codes 10-15 never occur in the counter and are shown blank.
module decod_bcd_7seg
    import placar_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        unique case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/placar_bcd_7segmentos.sv
// Two-digit BCD up/down score counter with segment decode and refresh clock.
// Define PLACAR_DEBOUNCE_EN to insert a debounce filter on each button.
module placar_bcd_7segmentos
    import placar_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int DEB_CYCLES  = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic on_off,
    input  logic btn_inc,
    input  logic btn_dec,
    input  logic clr,
    output logic clk_dp,
    output logic va,
    output logic vb,
    output logic vc,
    output logic vd,
    output logic ve,
    output logic vf,
    output logic vg,
    output logic pa,
    output logic pb,
    output logic pc,
    output logic pd,
    output logic pe,
    output logic pf,
    output logic pg
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(REFRESH_DIV - 1);

    if ((REFRESH_DIV < 1) || (DEB_CYCLES < 1)) begin : g_bad_param
        $error("placar_bcd_7segmentos: REFRESH_DIV and DEB_CYCLES must be >= 1");
    end

    logic [NBTN-1:0] w_btn_raw;
    logic [NBTN-1:0] r_sync1;
    logic [NBTN-1:0] r_sync2;
    logic [NBTN-1:0] w_lvl;
    logic [NBTN-1:0] r_lvl_d;
    logic [NBTN-1:0] r_arm;
    logic [NBTN-1:0] r_pulse;
    logic [1:0]      r_fill;

    placar_t         r_cnt;
    placar_t         w_cnt_nxt;
    logic            w_inc_p;
    logic            w_dec_p;

    logic [6:0]      w_seg_uni;
    logic [6:0]      w_seg_dez;
    logic [6:0]      r_seg_uni;
    logic [6:0]      r_seg_dez;

    logic [DIV_W-1:0] r_div;
    logic             r_clk_dp;

    assign w_btn_raw[BTN_INC] = btn_inc;
    assign w_btn_raw[BTN_DEC] = btn_dec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
        end
    end

`ifdef PLACAR_DEBOUNCE_EN
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES - 1);

    for (genvar gi = 0; gi < NBTN; gi++) begin : g_deb
        logic [DEB_W-1:0] r_deb_cnt;
        logic             r_deb_lvl;

        // Any cycle agreeing with the filtered level restarts the count.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_deb_cnt <= '0;
                r_deb_lvl <= 1'b0;
            end else if (r_sync2[gi] == r_deb_lvl) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == DEB_MAX) begin
                r_deb_cnt <= '0;
                r_deb_lvl <= r_sync2[gi];
            end else begin
                r_deb_cnt <= r_deb_cnt + DEB_W'(1);
            end
        end

        assign w_lvl[gi] = r_deb_lvl;
    end
`else
    assign w_lvl = r_sync2;
`endif

    // A button is armed only once its synchronised level is seen low after
    // the sync chain has refilled, so a press held through reset never steps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill  <= '0;
            r_arm   <= '0;
            r_lvl_d <= '0;
            r_pulse <= '0;
        end else begin
            r_fill  <= {r_fill[0], 1'b1};
            r_arm   <= r_arm | ({NBTN{r_fill[1]}} & ~r_sync2);
            r_lvl_d <= w_lvl;
            r_pulse <= w_lvl & ~r_lvl_d & r_arm;
        end
    end

    assign w_inc_p = r_pulse[BTN_INC];
    assign w_dec_p = r_pulse[BTN_DEC];

    always_comb begin
        w_cnt_nxt = r_cnt;
        priority case (1'b1)
            clr:                 w_cnt_nxt = PLACAR_ZERO;
            !on_off:             w_cnt_nxt = r_cnt;
            (w_inc_p & w_dec_p): w_cnt_nxt = r_cnt;
            w_inc_p:             w_cnt_nxt = placar_inc(r_cnt);
            w_dec_p:             w_cnt_nxt = placar_dec(r_cnt);
            default:             w_cnt_nxt = r_cnt;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= PLACAR_ZERO;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    decod_bcd_7seg u_dec_uni (
        .i_bcd (r_cnt.uni),
        .o_seg (w_seg_uni)
    );

    decod_bcd_7seg u_dec_dez (
        .i_bcd (r_cnt.dez),
        .o_seg (w_seg_dez)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_uni <= SEG_0;
            r_seg_dez <= SEG_0;
        end else begin
            r_seg_uni <= w_seg_uni;
            r_seg_dez <= w_seg_dez;
        end
    end

    // Free-running: neither on_off nor clr may disturb the display refresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div    <= '0;
            r_clk_dp <= 1'b0;
        end else if (r_div == DIV_MAX) begin
            r_div    <= '0;
            r_clk_dp <= ~r_clk_dp;
        end else begin
            r_div    <= r_div + DIV_W'(1);
        end
    end

    assign clk_dp = r_clk_dp;
    assign {va, vb, vc, vd, ve, vf, vg} = r_seg_uni;
    assign {pa, pb, pc, pd, pe, pf, pg} = r_seg_dez;

endmodule
